// File: rtl/hqm_AW_pkg.sv
// rtl/hqm_AW_pkg.sv - shared constants and state type for the AW 1:8 demux pipe.
package hqm_AW_pkg;

    localparam int HQM_AW_DEMUX8_LANES = 8;
    localparam int HQM_AW_DEMUX8_SELW  = 3;

    // Occupancy view of the main/skid pair, derived rather than stored.
    typedef enum logic [1:0] {
        DMX_EMPTY,
        DMX_ONE,
        DMX_TWO
    } hqm_aw_demux8_st_t;

endpackage

// File: rtl/hqm_aw_satcnt.sv
// rtl/hqm_aw_satcnt.sv - saturating up-counter; exists only when HQM_AW_DEMUX8_CNT_EN is defined.
`ifdef HQM_AW_DEMUX8_CNT_EN
module hqm_aw_satcnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule
`endif

// File: rtl/hqm_aw_demux8_pipe.sv
// rtl/hqm_aw_demux8_pipe.sv - registered 1:8 valid/ready demux with skid buffer.
// Per-lane pop counters are built only when HQM_AW_DEMUX8_CNT_EN is defined.
module hqm_aw_demux8_pipe
    import hqm_AW_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [HQM_AW_DEMUX8_SELW-1:0]            in_sel,
    input  logic [WIDTH-1:0]                         in_data,
    output logic [HQM_AW_DEMUX8_LANES-1:0]           out_valid,
    input  logic [HQM_AW_DEMUX8_LANES-1:0]           out_ready,
    output logic [WIDTH-1:0]                         out_data,
    output logic [HQM_AW_DEMUX8_LANES*CNT_WIDTH-1:0] lane_cnt
);

    logic                          main_v;
    logic                          skid_v;
    logic [HQM_AW_DEMUX8_SELW-1:0] main_sel;
    logic [HQM_AW_DEMUX8_SELW-1:0] skid_sel;
    logic [WIDTH-1:0]              main_data;
    logic [WIDTH-1:0]              skid_data;
    logic                          push;
    logic                          pop;
    hqm_aw_demux8_st_t             st;

    assign in_ready  = ~skid_v & ~rst;
    assign push      = in_valid & in_ready;
    assign pop       = main_v & out_ready[main_sel];
    assign out_valid = main_v ? (8'h01 << main_sel) : 8'h00;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_sel  <= '0;
            skid_sel  <= '0;
            main_data <= '0;
            skid_data <= '0;
        end else if (!main_v || pop) begin
            // Main register is free this cycle: the skid beat is older, so it goes first.
            if (skid_v) begin
                main_v    <= 1'b1;
                main_sel  <= skid_sel;
                main_data <= skid_data;
                skid_v    <= 1'b0;
            end else if (push) begin
                main_v    <= 1'b1;
                main_sel  <= in_sel;
                main_data <= in_data;
            end else begin
                main_v    <= 1'b0;
            end
        end else if (push) begin
            skid_v    <= 1'b1;
            skid_sel  <= in_sel;
            skid_data <= in_data;
        end
    end

    always_comb begin
        st = DMX_EMPTY;
        if (skid_v) begin
            st = DMX_TWO;
        end else if (main_v) begin
            st = DMX_ONE;
        end
    end

`ifdef HQM_AW_DEMUX8_CNT_EN
    for (genvar n = 0; n < HQM_AW_DEMUX8_LANES; n++) begin : g_cnt
        hqm_aw_satcnt #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk(clk),
            .rst(rst),
            .inc(pop && (main_sel == HQM_AW_DEMUX8_SELW'(n))),
            .cnt(lane_cnt[n*CNT_WIDTH +: CNT_WIDTH])
        );
    end
`else
    assign lane_cnt = '0;
`endif

    a_onehot_out: assert property (@(posedge clk) disable iff (rst) $onehot0(out_valid));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(skid_v && push));
    a_two_blocks: assert property (@(posedge clk) disable iff (rst) (st == DMX_TWO) |-> !in_ready);
    a_main_stable: assert property (@(posedge clk) disable iff (rst)
        (main_v && !pop) |=> (main_v && $stable(main_sel) && $stable(main_data)));

endmodule

// File: tb/tb_hqm_aw_demux8_pipe.sv
// tb/tb_hqm_aw_demux8_pipe.sv - randomized self-checking bench against a two-entry FIFO model.
module tb_hqm_aw_demux8_pipe;

    localparam int W  = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_sel;
    logic [W-1:0]  in_data;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready;
    logic [W-1:0]  out_data;
    logic [8*CW-1:0] lane_cnt;

    hqm_aw_demux8_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .lane_cnt(lane_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] data;
    } beat_t;

    beat_t       q[$];
    int unsigned cnt[8];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [7:0] exp_ov();
        return (q.size() > 0) ? (8'h01 << q[0].sel) : 8'h00;
    endfunction

    function automatic logic exp_ir();
        return !rst && (q.size() < 2);
    endfunction

    function automatic logic [8*CW-1:0] exp_cnt();
        logic [8*CW-1:0] v = '0;
`ifdef HQM_AW_DEMUX8_CNT_EN
        for (int n = 0; n < 8; n++) v[n*CW +: CW] = CW'(cnt[n]);
`endif
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        logic do_pop, do_push;
        if (rst) begin
            q.delete();
            for (int n = 0; n < 8; n++) cnt[n] = 0;
        end else begin
            do_pop  = (q.size() > 0) && out_ready[q[0].sel];
            do_push = in_valid && (q.size() < 2);
            if (do_pop) begin
                if (cnt[q[0].sel] < (1 << CW) - 1) cnt[q[0].sel]++;
                void'(q.pop_front());
            end
            if (do_push) q.push_back('{in_sel, in_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        tick(); tick();
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_out_valid got %h exp 00", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (lane_cnt !== '0) begin errors++; $display("FAIL reset_lane_cnt got %h exp 0", lane_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 8'hFF;
        in_valid = 1'b1; in_sel = 3'd5; in_data = 32'hA5A5_0001;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready0 got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 8'h20) begin errors++; $display("FAIL single_out_valid got %h exp 20", out_valid); end
        checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_out_data got %h exp a5a50001", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready1 got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL single_drained got %h exp 00", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sent[8];
        out_ready = 8'hFF;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; in_sel = 3'(i); in_data = $urandom; sent[i] = in_data;
            end else begin
                in_valid = 1'b0;
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready i=%0d got %b exp 1", i, in_ready); end
            if (i > 0) begin
                checks++; if (out_valid !== (8'h01 << (i - 1))) begin errors++; $display("FAIL b2b_out_valid i=%0d got %h exp %h", i, out_valid, 8'h01 << (i - 1)); end
                checks++; if (out_data !== sent[i-1]) begin errors++; $display("FAIL b2b_out_data i=%0d got %h exp %h", i, out_data, sent[i-1]); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        out_ready = 8'hFB;
        in_valid = 1'b1; in_sel = 3'd2; in_data = a;
        tick();
        in_sel = 3'd6; in_data = b;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept_b got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b1; in_sel = 3'd1; in_data = $urandom;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 8'h04) begin errors++; $display("FAIL stall_hold_valid k=%0d got %h exp 04", k, out_valid); end
            checks++; if (out_data !== a) begin errors++; $display("FAIL stall_hold_data k=%0d got %h exp %h", k, out_data, a); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready k=%0d got %b exp 0", k, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 8'hFF;
        checks++; if (out_valid !== 8'h04) begin errors++; $display("FAIL stall_release_a got %h exp 04", out_valid); end
        tick();
        checks++; if (out_valid !== 8'h40) begin errors++; $display("FAIL stall_b_valid got %h exp 40", out_valid); end
        checks++; if (out_data !== b) begin errors++; $display("FAIL stall_b_data got %h exp %h", out_data, b); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready_back got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL stall_drained got %h exp 00", out_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 3'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            checks++; if (in_ready !== exp_ir()) begin errors++; $display("FAIL rand_in_ready c=%0d got %b exp %b", c, in_ready, exp_ir()); end
            checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL rand_out_valid c=%0d got %h exp %h", c, out_valid, exp_ov()); end
            if (q.size() > 0) begin
                checks++; if (out_data !== q[0].data) begin errors++; $display("FAIL rand_out_data c=%0d got %h exp %h", c, out_data, q[0].data); end
            end
            checks++; if (lane_cnt !== exp_cnt()) begin errors++; $display("FAIL rand_lane_cnt c=%0d got %h exp %h", c, lane_cnt, exp_cnt()); end
            tick();
        end
        in_valid = 1'b0; out_ready = 8'hFF;
        tick(); tick();
        checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL rand_drain got %h exp %h", out_valid, exp_ov()); end
    endtask

    task automatic test_reset_in_two();
        out_ready = 8'h00;
        in_valid = 1'b1; in_sel = 3'($urandom); in_data = $urandom;
        tick(); tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL two_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL two_out_valid got %h exp %h", out_valid, exp_ov()); end
        rst = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_two_in_ready got %b exp 0", in_ready); end
        tick();
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL rst_two_out_valid got %h exp 00", out_valid); end
        checks++; if (lane_cnt !== '0) begin errors++; $display("FAIL rst_two_lane_cnt got %h exp 0", lane_cnt); end
        rst = 1'b0; out_ready = 8'hFF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_two_in_ready_after got %b exp 1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL rst_two_ghost k=%0d got %h exp 00", k, out_valid); end
        end
    endtask

    task automatic test_counters();
        logic [8*CW-1:0] want;
        want = '0;
`ifdef HQM_AW_DEMUX8_CNT_EN
        want[3*CW +: CW] = CW'(3);
`endif
        rst = 1'b1; in_valid = 1'b0; tick(); rst = 1'b0;
        out_ready = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_sel = 3'd3; in_data = $urandom;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        checks++; if (lane_cnt !== want) begin errors++; $display("FAIL cnt_lane3_sat got %h exp %h", lane_cnt, want); end
        checks++; if (lane_cnt !== exp_cnt()) begin errors++; $display("FAIL cnt_model got %h exp %h", lane_cnt, exp_cnt()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_in_two();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
